// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: virtual addresses, branch
// predictions and the per-entry record kept in queue storage.
package fetch_queue_pkg;

   typedef logic [31:0] Vaddr;

   typedef struct packed {
      logic PC_Vaild;
      logic Location;
      logic Taken;
      Vaddr Target;
   } Predict_Branch_S;

   typedef struct packed {
      Vaddr            PC;
      logic [31:0]     Inst;
      Predict_Branch_S Pred;
   } Fetch_Inst_S;

   localparam int FQ_DEPTH = 16;

   // A packet prediction belongs to exactly one slot; every other slot carries none.
   function automatic Predict_Branch_S slot_pred(input Predict_Branch_S p, input logic slot);
      slot_pred = (p.PC_Vaild && (p.Location == slot)) ? p : '0;
   endfunction

endpackage

// File: rtl/Fetch_Queue_Mem.sv
// Fetch queue entry storage: DEPTH x Fetch_Inst_S, two write ports and two
// asynchronous read ports.
module Fetch_Queue_Mem
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH
) (
   input  logic                     clk,
   input  logic                     we0,
   input  logic [$clog2(DEPTH)-1:0] waddr0,
   input  Fetch_Inst_S              wdata0,
   input  logic                     we1,
   input  logic [$clog2(DEPTH)-1:0] waddr1,
   input  Fetch_Inst_S              wdata1,
   input  logic [$clog2(DEPTH)-1:0] raddr0,
   output Fetch_Inst_S              rdata0,
   input  logic [$clog2(DEPTH)-1:0] raddr1,
   output Fetch_Inst_S              rdata1
);

   Fetch_Inst_S mem [DEPTH];

   // NOTE: storage is deliberately not reset; the pointers and count alone say
   // which entries are live, and a reset-free array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
   end

   assign rdata0 = mem[raddr0];
   assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Two-wide instruction fetch queue between fetch and decode. Defining
// FETCH_QUEUE_BYPASS_EN lets an empty queue forward incoming slots to the outputs.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            flush,
   input  logic [1:0]      in_valid,
   input  Vaddr            in_pc,
   input  logic [63:0]     in_inst,
   input  Predict_Branch_S in_pred,
   output logic            in_ready,
   output logic [1:0]      out_valid,
   output Vaddr            out_pc0,
   output Vaddr            out_pc1,
   output logic [31:0]     out_inst0,
   output logic [31:0]     out_inst1,
   output Predict_Branch_S out_pred0,
   output Predict_Branch_S out_pred1,
   input  logic [1:0]      out_pop
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;

   Fetch_Inst_S slot0, slot1, first_in, second_in;
   Fetch_Inst_S rd0, rd1, wdata0, wdata1;
   logic [1:0]  in_cnt, push_cnt, pop_cnt, wr_cnt, rd_adv;
   logic        push_ok, pop_legal, we0, we1;
   logic        bypass;

   assign in_ready = (count <= CW'(DEPTH - 2));
   assign in_cnt   = {1'b0, in_valid[0]} + {1'b0, in_valid[1]};
   assign push_ok  = (in_valid != 2'b00) && in_ready && !flush;
   assign push_cnt = push_ok ? in_cnt : 2'd0;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass = (count == '0) && !flush;
`else
   assign bypass = 1'b0;
`endif

   // Slots are compacted so a lone slot1 lands in the first free entry.
   always_comb begin
      slot0.PC   = in_pc;
      slot0.Inst = in_inst[31:0];
      slot0.Pred = slot_pred(in_pred, 1'b0);
      slot1.PC   = in_pc + 32'd4;
      slot1.Inst = in_inst[63:32];
      slot1.Pred = slot_pred(in_pred, 1'b1);
      first_in   = in_valid[0] ? slot0 : slot1;
      second_in  = slot1;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      out_valid = (count >= CW'(2)) ? 2'b11 : (count == CW'(1)) ? 2'b01 : 2'b00;
      out_pc0   = rd0.PC;
      out_pc1   = rd1.PC;
      out_inst0 = rd0.Inst;
      out_inst1 = rd1.Inst;
      out_pred0 = rd0.Pred;
      out_pred1 = rd1.Pred;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (bypass) begin
         out_valid = (in_cnt == 2'd2) ? 2'b11 : (in_cnt == 2'd1) ? 2'b01 : 2'b00;
         out_pc0   = first_in.PC;
         out_pc1   = second_in.PC;
         out_inst0 = first_in.Inst;
         out_inst1 = second_in.Inst;
         out_pred0 = first_in.Pred;
         out_pred1 = second_in.Pred;
      end
`endif
   end

   // Only 01 and 11 are meaningful pops, and only over entries actually presented.
   assign pop_legal = ((out_pop == 2'b01) && out_valid[0]) ||
                      ((out_pop == 2'b11) && out_valid[1]);
   assign pop_cnt   = pop_legal ? (out_pop[1] ? 2'd2 : 2'd1) : 2'd0;

   // In bypass the popped slots never reach storage; the rest are written normally.
   always_comb begin
      wr_cnt = push_cnt;
      rd_adv = pop_cnt;
      wdata0 = first_in;
      wdata1 = second_in;
      if (bypass) begin
         wr_cnt = push_cnt - pop_cnt;
         rd_adv = 2'd0;
         if (pop_cnt == 2'd1) wdata0 = second_in;
      end
   end

   assign we0 = (wr_cnt != 2'd0);
   assign we1 = (wr_cnt == 2'd2);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (flush) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         count  <= count + CW'(push_cnt) - CW'(pop_cnt);
         rd_ptr <= rd_ptr + AW'(rd_adv);
         wr_ptr <= wr_ptr + AW'(wr_cnt);
      end
   end

   Fetch_Queue_Mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk    (clk),
      .we0    (we0),
      .waddr0 (wr_ptr),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (wr_ptr + AW'(1)),
      .wdata1 (wdata1),
      .raddr0 (rd_ptr),
      .rdata0 (rd0),
      .raddr1 (rd_ptr + AW'(1)),
      .rdata1 (rd1)
   );

   illegal_pop_a : assert property (@(posedge clk) disable iff (!resetn)
      (out_pop == 2'b00) || pop_legal);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue; expected values are hand-computed
// constants plus a small queue of expected PCs.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = 16;

   logic            clk = 1'b0;
   logic            resetn;
   logic            flush;
   logic [1:0]      in_valid;
   Vaddr            in_pc;
   logic [63:0]     in_inst;
   Predict_Branch_S in_pred;
   logic            in_ready;
   logic [1:0]      out_valid;
   Vaddr            out_pc0, out_pc1;
   logic [31:0]     out_inst0, out_inst1;
   Predict_Branch_S out_pred0, out_pred1;
   logic [1:0]      out_pop;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] model_pc [$];

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .in_pred   (in_pred),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_pc0   (out_pc0),
      .out_pc1   (out_pc1),
      .out_inst0 (out_inst0),
      .out_inst1 (out_inst1),
      .out_pred0 (out_pred0),
      .out_pred1 (out_pred1),
      .out_pop   (out_pop)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'h5A5A_5A5A;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 2'b00;
      out_pop  = 2'b00;
      flush    = 1'b0;
      in_pred  = '0;
   endtask

   task automatic drive(input logic [1:0] vld, input logic [31:0] pc, input logic [1:0] pop);
      in_valid = vld;
      in_pc    = pc;
      in_inst  = {inst_of(pc + 32'd4), inst_of(pc)};
      out_pop  = pop;
   endtask

   // Applies one packet/pop for a cycle and keeps the expected-PC queue in step.
   task automatic step(input logic [1:0] vld, input logic [31:0] pc, input logic [1:0] pop);
      int npop;
      npop = (pop == 2'b11) ? 2 : (pop == 2'b01) ? 1 : 0;
      drive(vld, pc, pop);
      if (vld != 2'b00 && model_pc.size() <= DEPTH - 2) begin
         if (vld[0]) model_pc.push_back(pc);
         if (vld[1]) model_pc.push_back(pc + 32'd4);
      end
      for (int i = 0; i < npop; i++)
         if (model_pc.size() > 0) void'(model_pc.pop_front());
      cycle();
      idle();
   endtask

   task automatic test_reset();
      resetn  = 1'b0;
      idle();
      in_pc   = '0;
      in_inst = '0;
      #1;
      n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 00", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      model_pc.delete();
      n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_release_valid: got %b expected 00", out_valid); end
   endtask

   task automatic test_dual_push();
      drive(2'b11, 32'hBFC0_0000, 2'b00);
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      n_checks++; if (out_valid !== 2'b11) begin n_fail++; $display("FAIL dual_same_cycle: got %b expected 11", out_valid); end
`else
      n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL dual_same_cycle: got %b expected 00", out_valid); end
`endif
      step(2'b11, 32'hBFC0_0000, 2'b00);
      n_checks++; if (out_valid !== 2'b11) begin n_fail++; $display("FAIL dual_out_valid: got %b expected 11", out_valid); end
      n_checks++; if (out_pc0 !== 32'hBFC0_0000) begin n_fail++; $display("FAIL dual_pc0: got %h expected bfc00000", out_pc0); end
      n_checks++; if (out_pc1 !== 32'hBFC0_0004) begin n_fail++; $display("FAIL dual_pc1: got %h expected bfc00004", out_pc1); end
      n_checks++; if (out_inst0 !== 32'hE59A_5A5A) begin n_fail++; $display("FAIL dual_inst0: got %h expected e59a5a5a", out_inst0); end
      n_checks++; if (out_inst1 !== 32'hE59A_5A5E) begin n_fail++; $display("FAIL dual_inst1: got %h expected e59a5a5e", out_inst1); end
      step(2'b00, 32'h0, 2'b11);
      n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL dual_drain: got %b expected 00", out_valid); end
   endtask

   task automatic test_slot1_only();
      step(2'b10, 32'h8000_0008, 2'b00);
      n_checks++; if (out_valid !== 2'b01) begin n_fail++; $display("FAIL slot1_valid: got %b expected 01", out_valid); end
      n_checks++; if (out_pc0 !== 32'h8000_000C) begin n_fail++; $display("FAIL slot1_pc0: got %h expected 8000000c", out_pc0); end
      n_checks++; if (out_inst0 !== 32'hDA5A_5A56) begin n_fail++; $display("FAIL slot1_inst0: got %h expected da5a5a56", out_inst0); end
      step(2'b00, 32'h0, 2'b01);
      n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL slot1_drain: got %b expected 00", out_valid); end
   endtask

   task automatic test_pred_attach();
      in_pred = '0; in_pred.PC_Vaild = 1'b1; in_pred.Location = 1'b1; in_pred.Target = 32'h0000_2000;
      step(2'b11, 32'h0000_1000, 2'b00);
      n_checks++; if (out_pred1.PC_Vaild !== 1'b1) begin n_fail++; $display("FAIL pred_slot1_valid: got %b expected 1", out_pred1.PC_Vaild); end
      n_checks++; if (out_pred1.Target !== 32'h0000_2000) begin n_fail++; $display("FAIL pred_slot1_target: got %h expected 00002000", out_pred1.Target); end
      n_checks++; if (out_pred0.PC_Vaild !== 1'b0) begin n_fail++; $display("FAIL pred_slot0_clear: got %b expected 0", out_pred0.PC_Vaild); end
      step(2'b00, 32'h0, 2'b11);
      // Prediction aimed at slot0 while only slot1 is valid is dropped.
      in_pred = '0; in_pred.PC_Vaild = 1'b1; in_pred.Location = 1'b0; in_pred.Target = 32'h0000_3000;
      step(2'b10, 32'h0000_1010, 2'b00);
      n_checks++; if (out_pred0.PC_Vaild !== 1'b0) begin n_fail++; $display("FAIL pred_dropped: got %b expected 0", out_pred0.PC_Vaild); end
      step(2'b00, 32'h0, 2'b01);
      in_pred = '0; in_pred.PC_Vaild = 1'b1; in_pred.Location = 1'b0; in_pred.Target = 32'h0000_4000;
      step(2'b01, 32'h0000_1020, 2'b00);
      n_checks++; if (out_pred0.PC_Vaild !== 1'b1 || out_pred0.Target !== 32'h0000_4000) begin n_fail++; $display("FAIL pred_slot0: got %b/%h expected 1/00004000", out_pred0.PC_Vaild, out_pred0.Target); end
      step(2'b00, 32'h0, 2'b01);
   endtask

   task automatic test_full_wrap();
      logic [31:0] pc;
      logic [31:0] prev;
      logic [1:0]  exp_valid;
      int          guard;
      pc = 32'h8000_0000;
      for (int k = 0; k < 7; k++) begin
         step(2'b11, pc, 2'b00);
         pc += 32'd8;
      end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready14: got %b expected 1", in_ready); end
      step(2'b01, pc, 2'b00);
      pc += 32'd8;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready15: got %b expected 0", in_ready); end
      drive(2'b11, pc, 2'b11);
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_push_pop_ready: got %b expected 0", in_ready); end
      step(2'b11, pc, 2'b11);
      prev = 32'h0;
      for (int i = 0; i < 40; i++) begin
         drive(2'b11, pc, 2'b11);
         #1;
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready[%0d]: got %b expected 1", i, in_ready); end
         n_checks++; if (out_pc0 !== model_pc[0] || out_pc1 !== model_pc[1]) begin n_fail++; $display("FAIL wrap_pc[%0d]: got %h/%h expected %h/%h", i, out_pc0, out_pc1, model_pc[0], model_pc[1]); end
         n_checks++; if (out_pc0 <= prev) begin n_fail++; $display("FAIL wrap_monotonic[%0d]: got %h after %h", i, out_pc0, prev); end
         prev = out_pc0;
         step(2'b11, pc, 2'b11);
         pc += 32'd8;
      end
      guard = 0;
      while (model_pc.size() > 0 && guard < 20) begin
         exp_valid = (model_pc.size() >= 2) ? 2'b11 : 2'b01;
         n_checks++; if (out_valid !== exp_valid) begin n_fail++; $display("FAIL drain_valid: got %b expected %b", out_valid, exp_valid); end
         n_checks++; if (out_pc0 !== model_pc[0]) begin n_fail++; $display("FAIL drain_pc0: got %h expected %h", out_pc0, model_pc[0]); end
         step(2'b00, 32'h0, exp_valid);
         guard++;
      end
      n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL drain_empty: got %b expected 00", out_valid); end
   endtask

   task automatic test_flush();
      for (int k = 0; k < 4; k++) step(2'b11, 32'h9000_0000 + 32'(k * 8), 2'b00);
      step(2'b01, 32'h9000_0020, 2'b00);
      n_checks++; if (out_valid !== 2'b11) begin n_fail++; $display("FAIL flush_pre_valid: got %b expected 11", out_valid); end
      flush = 1'b1;
      drive(2'b11, 32'h9000_0028, 2'b11);
      cycle();
      idle();
      model_pc.delete();
      n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL flush_valid: got %b expected 00", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
      step(2'b11, 32'hA000_0000, 2'b00);
      step(2'b01, 32'hA000_0008, 2'b00);
      n_checks++; if (out_pc0 !== 32'hA000_0000 || out_pc1 !== 32'hA000_0004) begin n_fail++; $display("FAIL flush_after_pc: got %h/%h expected a0000000/a0000004", out_pc0, out_pc1); end
      step(2'b00, 32'h0, 2'b11);
      n_checks++; if (out_valid !== 2'b01 || out_pc0 !== 32'hA000_0008) begin n_fail++; $display("FAIL flush_after_tail: got %b/%h expected 01/a0000008", out_valid, out_pc0); end
      step(2'b00, 32'h0, 2'b01);
   endtask

   task automatic test_async_reset();
      step(2'b11, 32'hC000_0000, 2'b00);
      step(2'b11, 32'hC000_0008, 2'b00);
      n_checks++; if (out_valid !== 2'b11) begin n_fail++; $display("FAIL areset_pre_valid: got %b expected 11", out_valid); end
      #3;
      resetn = 1'b0;
      #1;
      n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL areset_valid: got %b expected 00", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %b expected 1", in_ready); end
      model_pc.delete();
      cycle();
      resetn = 1'b1;
      drive(2'b11, 32'hD000_0000, 2'b00);
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      n_checks++; if (out_valid !== 2'b11 || out_pc0 !== 32'hD000_0000) begin n_fail++; $display("FAIL bypass_same_cycle: got %b/%h expected 11/d0000000", out_valid, out_pc0); end
`else
      n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL no_bypass_same_cycle: got %b expected 00", out_valid); end
`endif
      step(2'b11, 32'hD000_0000, 2'b00);
      n_checks++; if (out_valid !== 2'b11 || out_pc1 !== 32'hD000_0004) begin n_fail++; $display("FAIL areset_push: got %b/%h expected 11/d0000004", out_valid, out_pc1); end
      step(2'b00, 32'h0, 2'b11);
      n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL areset_drain: got %b expected 00", out_valid); end
`ifdef FETCH_QUEUE_BYPASS_EN
      step(2'b11, 32'hE000_0000, 2'b01);
      n_checks++; if (out_valid !== 2'b01 || out_pc0 !== 32'hE000_0004) begin n_fail++; $display("FAIL bypass_partial_pop: got %b/%h expected 01/e0000004", out_valid, out_pc0); end
      step(2'b00, 32'h0, 2'b01);
`endif
   endtask

   initial begin
      test_reset();
      test_dual_push();
      test_slot1_only();
      test_pred_attach();
      test_full_wrap();
      test_flush();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning instruction entries held; power of two, at least 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port flush, input, 1, discards all queued and incoming instructions (mispredict or exception redirect).
REQ-005 SHALL have port in_valid, input, 2, slot mask of the fetch packet: bit0 = inst at in_pc, bit1 = inst at in_pc+4. Fetch clears the bit of any fake slot.
REQ-006 SHALL have port in_pc, input, 32 (Vaddr), packet address, 8-byte aligned.
REQ-007 SHALL have port in_inst, input, 64: [31:0] slot0, [63:32] slot1.
REQ-008 SHALL have port in_pred, input, Predict_Branch_S, the prediction for this packet.
REQ-009 SHALL have port in_ready, output, 1, queue accepts a packet this cycle.
REQ-010 SHALL have ports out_valid, output, 2: head instructions present, only 00, 01 or 11.
REQ-011 SHALL have ports out_pc0/out_pc1 (32), out_inst0/out_inst1 (32) and out_pred0/out_pred1 (Predict_Branch_S), all outputs, describing the oldest and second-oldest entries.
REQ-012 SHALL have port out_pop, input, 2, decode consumes head entries: 00, 01 or 11 only.

Function
REQ-013 Push SHALL occur when in_valid != 00 and in_ready = 1; valid slots are written in address order, compacted, at consecutive entries.
REQ-014 An entry's PC SHALL be in_pc for slot0 and in_pc+4 for slot1.
REQ-015 in_pred SHALL attach only to the slot selected by in_pred.Location when in_pred.PC_Vaild = 1. The other slot stores PC_Vaild = 0. If the selected slot is invalid, the prediction is dropped.
REQ-016 in_ready SHALL equal (count <= DEPTH-2), computed from the registered count. No credit is given for a pop in the same cycle.
REQ-017 out_valid SHALL be 11 when count >= 2, 01 when count = 1, and 00 when empty.
REQ-018 Pop of the masked entries SHALL occur when out_pop is a subset of out_valid. Pop values 10 or exceeding out_valid SHALL be ignored, and a simulation assertion SHALL fire.
REQ-019 count_next SHALL equal count + pushed - popped, 0..DEPTH. Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-020 Simultaneous push and pop SHALL both take effect. The order of entries is preserved across pointer wrap-around.
REQ-021 flush SHALL have priority: the next cycle count = 0, pointers = 0, and same-cycle push and pop are discarded. out_valid = 00 and in_ready = 1 the cycle after flush.
REQ-022 A pushed instruction SHALL first appear on the outputs in the cycle after the push (unless REQ-026 applies).
REQ-023 Outputs SHALL be driven from the head pointer. out_*1 fields are don't-care when out_valid[1] = 0.

Reset
REQ-024 While resetn = 0: count = 0, pointers = 0, out_valid = 00, in_ready = 1, independent of clk. Assertion of resetn mid-operation discards all contents.
REQ-025 Entry storage SHALL NOT be reset.

Configuration
REQ-026 With FETCH_QUEUE_BYPASS_EN defined:
- when count = 0 and flush = 0, the incoming valid slots SHALL be presented combinationally on out_* in the same cycle;
- slots popped that cycle SHALL NOT be written;
- remaining slots SHALL be written normally.
REQ-027 Without FETCH_QUEUE_BYPASS_EN, no combinational in-to-out path SHALL exist and REQ-022 latency is exactly 1 cycle.

Structure
REQ-028 The shared package SHALL hold typedef Fetch_Inst_S {Vaddr PC; logic[31:0] Inst; Predict_Branch_S Pred} and constant FQ_DEPTH = 16. Vaddr and Predict_Branch_S are the existing package types.
REQ-029 Storage SHALL be sub-module Fetch_Queue_Mem: DEPTH x Fetch_Inst_S, two write ports, two asynchronous read ports, no reset. Pointer and count logic stays in fetch_queue.

Verification
REQ-030 Reset, then push in_pc=0xBFC00000, in_valid=11, no pop.
- Expected: next cycle out_valid=11, out_pc0=0xBFC00000, out_pc1=0xBFC00004.
REQ-031 Push in_valid=10 at in_pc=0x80000008 into an empty queue.
- Expected: out_valid=01, out_pc0=0x8000000C.
REQ-032 Push in_valid=11 with in_pred.PC_Vaild=1 and Location=1.
- Expected: out_pred1.PC_Vaild=1 and out_pred0.PC_Vaild=0.
REQ-033 Fill to count=15, then push 11 with pop 11 at the same time.
- Expected: in_ready=0, the push is not taken, count becomes 13.
- Continue with 40 cycles of push 11 / pop 11: pointers wrap and the PC sequence stays monotonic.
REQ-034 With count=9, assert flush together with push 11 and pop 11.
- Expected: next cycle out_valid=00, in_ready=1, and the later push is observed in order.
REQ-035 Assert resetn=0 asynchronously mid-stream.
- Expected: out_valid=00 before the next clk edge. With FETCH_QUEUE_BYPASS_EN, a push into the empty queue shows out_valid=11 the same cycle.
